wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between two requesters: ALU writeback (req0) and load unit (req1).

---
 rtl/wb_port_arbiter.sv | 124 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. Two single-entry slots (ALU and load)
// compete for one write per cycle. The order is round-robin, except that on a
// same-register conflict the older entry wins. The grant is computed from the
// next-cycle slot contents and registered, so wb_* reflect the slots as they
// stand at the start of each cycle. wb_sel drives an external 2:1 data mux.
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic [DATA_W-1:0] slot0_q,
  output logic [DATA_W-1:0] slot1_q,
  output logic              wb_sel,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr
);

  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

  state_t              state_q;
  logic                v0_q, v1_q, v0_d, v1_d;
  logic [ADDR_W-1:0]   a0_q, a1_q, a0_d, a1_d;
  logic [DATA_W-1:0]   slot0_d, slot1_d;
  logic                age_q, age_d;      // 1: slot1 holds the older entry
  logic                rr_q, rr_d;        // last slot that won a round-robin pick
  logic                rrupd_q;           // current grant was a round-robin pick
  logic                sel_q, wb_en_q;
  logic [ADDR_W-1:0]   wb_addr_q;
  logic                g0, g1, acc0, acc1;
  logic                n_any, n_sel, n_rr;
  logic [ADDR_W-1:0]   n_addr;

  // Returns {any grant, granted slot, decision was round-robin}.
  function automatic logic [2:0] arb(input logic v0, input logic v1,
                                     input logic [ADDR_W-1:0] a0,
                                     input logic [ADDR_W-1:0] a1,
                                     input logic age, input logic rr);
    logic conflict;
    conflict = v0 && v1 && (a0 == a1) && (a0 != '0);
    if (v0 && v1) begin
      if (conflict) arb = {1'b1, age, 1'b0};
      else          arb = {1'b1, ~rr, 1'b1};
    end else begin
      arb = {v0 | v1, v1, 1'b0};
    end
  endfunction

  assign g0         = (state_q == G0);
  assign g1         = (state_q == G1);
  assign req0_ready = !v0_q || g0;
  assign req1_ready = !v1_q || g1;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign wb_sel     = sel_q;
  assign wb_en      = wb_en_q;
  assign wb_addr    = wb_addr_q;

  // Next slot contents, age and round-robin pointer, then the next grant.
  always_comb begin
    v0_d    = !flush && (acc0 || (v0_q && !g0));
    v1_d    = !flush && (acc1 || (v1_q && !g1));
    a0_d    = (acc0 && !flush) ? req0_addr : a0_q;
    a1_d    = (acc1 && !flush) ? req1_addr : a1_q;
    slot0_d = (acc0 && !flush) ? req0_data : slot0_q;
    slot1_d = (acc1 && !flush) ? req1_data : slot1_q;
    // A newly accepted entry is younger than whatever is already resident.
    age_d   = age_q;
    if (flush)             age_d = 1'b0;
    else if (acc0 && acc1) age_d = 1'b0;
    else if (acc0)         age_d = 1'b1;
    else if (acc1)         age_d = 1'b0;
    rr_d    = (!flush && rrupd_q) ? g1 : rr_q;
    {n_any, n_sel, n_rr} = arb(v0_d, v1_d, a0_d, a1_d, age_d, rr_d);
    n_addr  = n_sel ? a1_d : a0_d;
  end

  // Grant FSM with registered write-port outputs, plus slot storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      a0_q      <= '0;
      a1_q      <= '0;
      slot0_q   <= '0;
      slot1_q   <= '0;
      age_q     <= 1'b0;
      rr_q      <= 1'b1;
      rrupd_q   <= 1'b0;
      sel_q     <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
    end else begin
      v0_q      <= v0_d;
      v1_q      <= v1_d;
      a0_q      <= a0_d;
      a1_q      <= a1_d;
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      age_q     <= age_d;
      rr_q      <= rr_d;
      rrupd_q   <= n_rr;
      wb_en_q   <= n_any && (n_addr != '0);
      wb_addr_q <= n_any ? n_addr : '0;
      if (n_any) sel_q <= n_sel;
      case ({n_any, n_sel})
        2'b10:   state_q <= G0;
        2'b11:   state_q <= G1;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a table of single-cycle vectors plus
// hand-written sequences for conflicts, flush and asynchronous reset.
module tb_wb_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready, wb_sel, wb_en;
  logic [DW-1:0] slot0_q, slot1_q;
  logic [AW-1:0] wb_addr;

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .slot0_q(slot0_q), .slot1_q(slot1_q),
    .wb_sel(wb_sel), .wb_en(wb_en), .wb_addr(wb_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic          v1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic          en; logic sel; logic [AW-1:0] addr; logic [DW-1:0] data;
    logic          r0; logic r1;
  } vec_t;

  vec_t tbl [15];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic en, input logic sel, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input logic r0, input logic r1);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.en = en; v.sel = sel; v.addr = addr; v.data = data; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Full write-port check; address and mux data only matter on a real write.
  task automatic chk_wb(input string nm, input logic en, input logic sel,
                        input logic [AW-1:0] addr, input logic [DW-1:0] data);
    chk({nm, ".en"},  {31'd0, wb_en},  {31'd0, en});
    chk({nm, ".sel"}, {31'd0, wb_sel}, {31'd0, sel});
    if (en) begin
      chk({nm, ".addr"}, {27'd0, wb_addr}, {27'd0, addr});
      chk({nm, ".data"}, wb_sel ? slot1_q : slot0_q, data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          v0 a0     d0             v1 a1     d1             en sel addr   data           r0 r1
    tbl[0]  = mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,        1, 0, 5'd5, 32'hDEADBEEF, 1, 1);
    tbl[1]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,        1, 1);
    tbl[2]  = mk(1, 5'd3, 32'h100,      1, 5'd7, 32'h200,      1, 0, 5'd3, 32'h100,      1, 0);
    tbl[3]  = mk(1, 5'd3, 32'h101,      1, 5'd7, 32'h201,      1, 1, 5'd7, 32'h200,      0, 1);
    tbl[4]  = mk(1, 5'd3, 32'h102,      1, 5'd7, 32'h201,      1, 0, 5'd3, 32'h101,      1, 0);
    tbl[5]  = mk(1, 5'd3, 32'h102,      1, 5'd7, 32'h202,      1, 1, 5'd7, 32'h201,      0, 1);
    tbl[6]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 0, 5'd3, 32'h102,      1, 1);
    tbl[7]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,        1, 1);
    tbl[8]  = mk(1, 5'd0, 32'h1234,     0, 5'd0, 32'h0,        0, 0, 5'd0, 32'h0,        1, 1);
    tbl[9]  = mk(1, 5'd6, 32'hCAFE,     0, 5'd0, 32'h0,        1, 0, 5'd6, 32'hCAFE,     1, 1);
    tbl[10] = mk(0, 5'd0, 32'h0,        1, 5'd8, 32'hBEEF0001, 1, 1, 5'd8, 32'hBEEF0001, 1, 1);
    tbl[11] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 1, 5'd0, 32'h0,        1, 1);
    tbl[12] = mk(1, 5'd0, 32'h55,       1, 5'd2, 32'h66,       0, 0, 5'd0, 32'h0,        1, 0);
    tbl[13] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 1, 5'd2, 32'h66,       1, 1);
    tbl[14] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 1, 5'd0, 32'h0,        1, 1);

    // Reset state.
    #12;
    chk("rst.en",    {31'd0, wb_en},      32'd0);
    chk("rst.sel",   {31'd0, wb_sel},     32'd0);
    chk("rst.addr",  {27'd0, wb_addr},    32'd0);
    chk("rst.s0",    slot0_q,             32'd0);
    chk("rst.s1",    slot1_q,             32'd0);
    chk("rst.r0",    {31'd0, req0_ready}, 32'd1);
    chk("rst.r1",    {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Vector table: single writes, round-robin stream, zero register, sel hold.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1);
      cyc();
      chk_wb($sformatf("v%0d", i), tbl[i].en, tbl[i].sel, tbl[i].addr, tbl[i].data);
      chk($sformatf("v%0d.r0", i), {31'd0, req0_ready}, {31'd0, tbl[i].r0});
      chk($sformatf("v%0d.r1", i), {31'd0, req1_ready}, {31'd0, tbl[i].r1});
    end
    idle();

    // Same register: load entry first, ALU entry one cycle later; ALU data lands last.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h901);
    cyc();
    chk_wb("cf1.a", 1'b1, 1'b1, 5'd9, 32'h901);
    drive(1'b1, 5'd9, 32'h900, 1'b0, 5'd0, 32'h0);
    cyc();
    chk_wb("cf1.b", 1'b1, 1'b0, 5'd9, 32'h900);
    idle();
    cyc();
    chk_wb("cf1.c", 1'b0, 1'b0, 5'd0, 32'h0);

    // Same register loaded together while round-robin points at slot1: slot0 is older, goes first.
    drive(1'b1, 5'd9, 32'hA0, 1'b1, 5'd9, 32'hA1);
    cyc();
    chk_wb("cf2.a", 1'b1, 1'b0, 5'd9, 32'hA0);
    idle();
    cyc();
    chk_wb("cf2.b", 1'b1, 1'b1, 5'd9, 32'hA1);
    cyc();
    chk_wb("cf2.c", 1'b0, 1'b1, 5'd0, 32'h0);

    // Flush with both slots full and a new load arriving: the current grant still
    // writes, nothing else does, and the round-robin pointer is left alone.
    drive(1'b1, 5'd10, 32'h10, 1'b1, 5'd11, 32'h11);
    cyc();
    chk_wb("fl.a", 1'b1, 1'b1, 5'd11, 32'h11);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h77);
    flush = 1'b1;
    #1;
    chk_wb("fl.cur", 1'b1, 1'b1, 5'd11, 32'h11);
    cyc();
    flush = 1'b0;
    idle();
    chk("fl.en",  {31'd0, wb_en},      32'd0);
    chk("fl.r0",  {31'd0, req0_ready}, 32'd1);
    chk("fl.r1",  {31'd0, req1_ready}, 32'd1);
    cyc();
    chk("fl.en2", {31'd0, wb_en},      32'd0);
    drive(1'b1, 5'd13, 32'h13, 1'b1, 5'd14, 32'h14);
    cyc();
    chk_wb("fl.rr.a", 1'b1, 1'b1, 5'd14, 32'h14);
    idle();
    cyc();
    chk_wb("fl.rr.b", 1'b1, 1'b0, 5'd13, 32'h13);
    cyc();

    // Asynchronous reset mid-stream with both slots full.
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
    cyc();
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ar.en", {31'd0, wb_en},      32'd0);
    chk("ar.r0", {31'd0, req0_ready}, 32'd1);
    chk("ar.r1", {31'd0, req1_ready}, 32'd1);
    chk("ar.s0", slot0_q,             32'd0);
    chk("ar.s1", slot1_q,             32'd0);
    cyc();
    chk("ar.en2", {31'd0, wb_en},     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("ar.en3", {31'd0, wb_en},     32'd0);
    drive(1'b1, 5'd5, 32'h5555, 1'b0, 5'd0, 32'h0);
    cyc();
    chk_wb("ar.post", 1'b1, 1'b0, 5'd5, 32'h5555);
    idle();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
